// File: rtl/instr_fetch_stage.sv
// Fetch stage of the 16-bit-instruction lab CPU.
// Owns the PC, drives the instruction RAM byte address and captures the
// returned word into the fetch/decode pipeline register (IR, PC, PC+2, valid).
// Handles decode stalls, branch/jump redirects with flush, and halt on a
// dedicated halt encoding. A saturating counter tracks issued instructions.
module instr_fetch_stage #(
  parameter int                  ADDR_W    = 8,
  parameter int                  INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC  = 8'h00,
  parameter logic [INSTR_W-1:0]  HALT_WORD = 16'h0000,
  parameter int                  CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  npc_out,
  output logic               valid_out,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [INSTR_W-1:0] ir_nxt;
  logic [ADDR_W-1:0]  pc_out_nxt;
  logic [ADDR_W-1:0]  npc_nxt;
  logic               valid_nxt;
  logic               halted_nxt;
  logic [CNT_W-1:0]   count_nxt;

  // The RAM address is the PC register itself, so it only moves on clock
  // edges or reset and never follows input glitches.
  assign imem_addr = pc;

  // Next-state and next-register computation, in edge priority order:
  // redirect, then per-state behaviour (stall, halt detect, normal fetch).
  always_comb begin
    // NOTE: every signal gets a hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir_out;
    pc_out_nxt = pc_out;
    npc_nxt    = npc_out;
    valid_nxt  = valid_out;
    halted_nxt = halted;
    count_nxt  = fetch_count;

    if (redirect) begin
      // Flush the word in flight; IR/PC_OUT keep their old contents.
      pc_nxt     = {redirect_pc[ADDR_W-1:1], 1'b0};
      valid_nxt  = 1'b0;
      halted_nxt = 1'b0;
      state_nxt  = RUN;
    end else begin
      unique case (state)
        BOOT: begin
          // RAM is loaded during reset; spend one cycle before fetching.
          state_nxt = RUN;
        end
        RUN: begin
          if (!stall) begin
            if (imem_data == HALT_WORD) begin
              valid_nxt  = 1'b0;
              halted_nxt = 1'b1;
              state_nxt  = HALT;
            end else begin
              ir_nxt     = imem_data;
              pc_out_nxt = pc;
              npc_nxt    = pc + PC_STEP;
              valid_nxt  = 1'b1;
              pc_nxt     = pc + PC_STEP;
              if (fetch_count != CNT_MAX) begin
                count_nxt = fetch_count + CNT_W'(1);
              end
            end
          end
        end
        HALT: begin
          valid_nxt = 1'b0;
        end
        default: begin
          state_nxt = BOOT;
        end
      endcase
    end
  end

  // State and pipeline registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      ir_out      <= '0;
      pc_out      <= '0;
      npc_out     <= '0;
      valid_out   <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ir_out      <= ir_nxt;
      pc_out      <= pc_out_nxt;
      npc_out     <= npc_nxt;
      valid_out   <= valid_nxt;
      halted      <= halted_nxt;
      fetch_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios plus
// randomized stall/redirect traffic, compared against a behavioural model.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [15:0] ir_out;
  logic [7:0]  pc_out;
  logic [7:0]  npc_out;
  logic        valid_out;
  logic        halted;
  logic [15:0] fetch_count;

  int errors = 0;
  int checks = 0;

  // Instruction RAM: 128 words, byte addressed.
  logic [15:0] mem [128];

  // Behavioural model of the architectural view.
  int          m_pc;
  logic [15:0] m_ir;
  int          m_pc_out;
  int          m_npc;
  bit          m_valid;
  bit          m_halted;
  bit          m_boot;
  int          m_count;

  instr_fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir_out      (ir_out),
    .pc_out      (pc_out),
    .npc_out     (npc_out),
    .valid_out   (valid_out),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:1]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = 0;
    m_ir     = 16'h0000;
    m_pc_out = 0;
    m_npc    = 0;
    m_valid  = 1'b0;
    m_halted = 1'b0;
    m_boot   = 1'b1;
    m_count  = 0;
  endtask

  // One clock edge of the fetch stage, described from its rules.
  task automatic model_edge();
    logic [15:0] word;
    if (redirect) begin
      m_pc     = int'(redirect_pc) & 'hFE;
      m_valid  = 1'b0;
      m_halted = 1'b0;
      m_boot   = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (!stall) begin
      word = mem[m_pc / 2];
      if (word == 16'h0000) begin
        m_valid  = 1'b0;
        m_halted = 1'b1;
      end else begin
        m_ir     = word;
        m_pc_out = m_pc;
        m_npc    = (m_pc + 2) % 256;
        m_valid  = 1'b1;
        m_pc     = (m_pc + 2) % 256;
        if (m_count < 65535) m_count = m_count + 1;
      end
    end
  endtask

  task automatic check_all();
    check("imem_addr",   32'(imem_addr),   32'(m_pc));
    check("ir_out",      32'(ir_out),      32'(m_ir));
    check("pc_out",      32'(pc_out),      32'(m_pc_out));
    check("npc_out",     32'(npc_out),     32'(m_npc));
    check("valid_out",   32'(valid_out),   32'(m_valid));
    check("halted",      32'(halted),      32'(m_halted));
    check("fetch_count", 32'(fetch_count), 32'(m_count));
  endtask

  task automatic set_in(input bit st, input bit rd, input logic [7:0] rpc);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  // Inputs are driven #1 after a rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asserts reset at the current time (between edges) and releases it on the
  // following falling edge, so the next rising edge is the BOOT cycle.
  task automatic do_reset();
    set_in(1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_nonzero();
    for (int i = 0; i < 128; i++) mem[i] = 16'(1000 + i * 37);
  endtask

  initial begin
    fill_nonzero();
    mem[0] = 16'hF491;
    mem[1] = 16'hF249;
    mem[2] = 16'h0000;

    // Reset, boot, two issues, then halt on the zero word at 04.
    #2;
    do_reset();
    tick();
    check("t1_boot_valid", 32'(valid_out), 32'd0);
    tick();
    check("t1_ir0",  32'(ir_out),  32'h0000_F491);
    check("t1_pc0",  32'(pc_out),  32'h00);
    check("t1_npc0", 32'(npc_out), 32'h02);
    tick();
    check("t1_ir1",  32'(ir_out),  32'h0000_F249);
    check("t1_pc1",  32'(pc_out),  32'h02);
    tick();
    check("t1_halted", 32'(halted),      32'd1);
    check("t1_valid",  32'(valid_out),   32'd0);
    check("t1_pc",     32'(imem_addr),   32'h04);
    check("t1_count",  32'(fetch_count), 32'd2);
    set_in(1'b1, 1'b0, 8'h00);
    tick();
    check("t1_stall_in_halt", 32'(halted), 32'd1);

    // Leave HALT by redirect to 10; the word at 10 issues on the next edge.
    set_in(1'b0, 1'b1, 8'h10);
    tick();
    check("t4_halted", 32'(halted), 32'd0);
    set_in(1'b0, 1'b0, 8'h00);
    tick();
    check("t4_pc_out", 32'(pc_out), 32'h10);
    check("t4_ir",     32'(ir_out), 32'(mem[8]));

    // Stall three cycles at PC=06, then resume without skip or duplicate.
    set_in(1'b0, 1'b1, 8'h06);
    tick();
    set_in(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_addr_held", 32'(imem_addr), 32'h06);
    end
    set_in(1'b0, 1'b0, 8'h00);
    tick();
    check("t2_resume_pc", 32'(pc_out), 32'h06);
    tick();
    check("t2_next_pc", 32'(pc_out), 32'h08);

    // Redirect wins over stall, bit 0 of the target is dropped.
    set_in(1'b1, 1'b1, 8'h21);
    tick();
    check("t3_pc",    32'(imem_addr), 32'h20);
    check("t3_valid", 32'(valid_out), 32'd0);
    set_in(1'b0, 1'b0, 8'h00);
    tick();
    check("t3_pc_out", 32'(pc_out), 32'h20);

    // Address wrap from FC.
    set_in(1'b0, 1'b1, 8'hFC);
    tick();
    set_in(1'b0, 1'b0, 8'h00);
    tick();
    check("t5_pc_fc", 32'(pc_out), 32'hFC);
    tick();
    check("t5_pc_fe",  32'(pc_out),  32'hFE);
    check("t5_npc_fe", 32'(npc_out), 32'h00);
    tick();
    check("t5_pc_00", 32'(pc_out), 32'h00);

    // Asynchronous reset mid-cycle, then saturate the counter.
    mem[2] = 16'h1234;
    do_reset();
    check("t6_async_valid", 32'(valid_out), 32'd0);
    check("t6_async_count", 32'(fetch_count), 32'd0);
    for (int i = 0; i < 65540; i++) tick();
    check("t6_saturated", 32'(fetch_count), 32'h0000_FFFF);

    // Random traffic with occasional halt words.
    for (int i = 0; i < 128; i++)
      mem[i] = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 8'($urandom_range(0, 255)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
